// File: rtl/bram18k_arb_pkg.sv
// Shared types and constants for the BRAM18K port arbiter.
// Read latency depends on the BRAM18K_ARB_RDATA_REG_EN macro.
package bram18k_arb_pkg;

   localparam int MAX_REQ  = 8;
   localparam int ID_WIDTH = $clog2((MAX_REQ > 2) ? MAX_REQ : 2);

`ifdef BRAM18K_ARB_RDATA_REG_EN
   localparam int RD_LATENCY = 3;
`else
   localparam int RD_LATENCY = 2;
`endif

   localparam int TAG_STAGES = RD_LATENCY;

   typedef struct packed {
      logic                valid;
      logic [ID_WIDTH-1:0] id;
   } rd_tag_t;

   function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id,
                                                   input int                  n);
      if (int'(id) >= n - 1) return '0;
      return id + 1'b1;
   endfunction

endpackage

// File: rtl/bram18k_port_arbiter_rr_arbiter.sv
// Round-robin grant with a pointer register.
// The pointer moves past the winner only when the grant is accepted.
module rr_arbiter
   import bram18k_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  valid,
   input  logic                accept,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_id
);

   logic [ID_WIDTH-1:0] ptr_q, ptr_d;
   logic                found;

   // First pass searches from the pointer upward, second pass wraps from zero.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && valid[k] && (k >= int'(ptr_q))) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            grant_id = ID_WIDTH'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && valid[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            grant_id = ID_WIDTH'(k);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = next_id(grant_id, NUM_REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/bram18k_port_arbiter.sv
// Shares one BRAM18K port among NUM_REQ requesters and routes read data back by tag.
// BRAM18K_ARB_RDATA_REG_EN adds one register stage on the read response path.
module bram18k_port_arbiter
   import bram18k_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 18
) (
   input  logic                          CLK_i,
   input  logic                          RST_ni,
   input  logic [NUM_REQ-1:0]            REQ_VALID_i,
   input  logic [NUM_REQ-1:0]            REQ_WE_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA_i,
   output logic [NUM_REQ-1:0]            REQ_READY_o,
   output logic [NUM_REQ-1:0]            RSP_VALID_o,
   output logic [DATA_WIDTH-1:0]         RSP_RDATA_o,
   output logic                          RAM_WEN_o,
   output logic                          RAM_REN_o,
   output logic [ADDR_WIDTH-1:0]         RAM_WR_ADDR_o,
   output logic [ADDR_WIDTH-1:0]         RAM_RD_ADDR_o,
   output logic [DATA_WIDTH-1:0]         RAM_WDATA_o,
   input  logic [DATA_WIDTH-1:0]         RAM_RDATA_i
);

   logic [NUM_REQ-1:0]    grant;
   logic [ID_WIDTH-1:0]   grant_id;
   logic                  accept;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic                  ram_wen_q, ram_wen_d;
   logic                  ram_ren_q, ram_ren_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   rd_tag_t [TAG_STAGES-1:0] tag_q, tag_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [DATA_WIDTH-1:0] rsp_src;
   rd_tag_t               last_tag;

`ifdef BRAM18K_ARB_RDATA_REG_EN
   logic [DATA_WIDTH-1:0] rdata_pipe_q, rdata_pipe_d;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clk      (CLK_i),
      .rst_n    (RST_ni),
      .valid    (REQ_VALID_i),
      .accept   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_comb begin
      accept    = |grant;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_we    = REQ_WE_i[k];
            sel_addr  = REQ_ADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = REQ_WDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Addresses and write data hold between commands; only the strobes drop.
   always_comb begin
      ram_wen_d = accept & sel_we;
      ram_ren_d = accept & ~sel_we;
      wr_addr_d = ram_wen_d ? sel_addr  : wr_addr_q;
      wdata_d   = ram_wen_d ? sel_wdata : wdata_q;
      rd_addr_d = ram_ren_d ? sel_addr  : rd_addr_q;

      tag_d[0].valid = ram_ren_d;
      tag_d[0].id    = grant_id;
      for (int s = 1; s < TAG_STAGES; s++) tag_d[s] = tag_q[s-1];
   end

`ifdef BRAM18K_ARB_RDATA_REG_EN
   // RAM data for the stage-1 tag is present now; capture it before the next read overwrites it.
   always_comb begin
      rdata_pipe_d = tag_q[TAG_STAGES-2].valid ? RAM_RDATA_i : rdata_pipe_q;
      rsp_src      = rdata_pipe_q;
   end
`else
   always_comb begin
      rsp_src = RAM_RDATA_i;
   end
`endif

   always_comb begin
      last_tag    = tag_q[TAG_STAGES-1];
      rsp_valid_d = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rsp_valid_d[k] = last_tag.valid && (last_tag.id == ID_WIDTH'(k));
      end
      rsp_rdata_d = last_tag.valid ? rsp_src : rsp_rdata_q;
   end

   always_ff @(posedge CLK_i or negedge RST_ni) begin
      if (!RST_ni) begin
         ram_wen_q    <= 1'b0;
         ram_ren_q    <= 1'b0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         wdata_q      <= '0;
         tag_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
`ifdef BRAM18K_ARB_RDATA_REG_EN
         rdata_pipe_q <= '0;
`endif
      end else begin
         ram_wen_q    <= ram_wen_d;
         ram_ren_q    <= ram_ren_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         wdata_q      <= wdata_d;
         tag_q        <= tag_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
`ifdef BRAM18K_ARB_RDATA_REG_EN
         rdata_pipe_q <= rdata_pipe_d;
`endif
      end
   end

   assign REQ_READY_o   = grant;
   assign RSP_VALID_o   = rsp_valid_q;
   assign RSP_RDATA_o   = rsp_rdata_q;
   assign RAM_WEN_o     = ram_wen_q;
   assign RAM_REN_o     = ram_ren_q;
   assign RAM_WR_ADDR_o = wr_addr_q;
   assign RAM_RD_ADDR_o = rd_addr_q;
   assign RAM_WDATA_o   = wdata_q;

endmodule

// File: tb/tb_bram18k_port_arbiter.sv
// Self-checking bench for bram18k_port_arbiter with a behavioural BRAM and a response scoreboard.
// Honours BRAM18K_ARB_RDATA_REG_EN for the expected read latency.
module tb_bram18k_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 18;
`ifdef BRAM18K_ARB_RDATA_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            ram_wen, ram_ren;
   logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
   logic [DW-1:0]   ram_wdata, ram_rdata;

   logic [DW-1:0]   mem     [0:(1<<AW)-1];
   logic [DW-1:0]   ref_mem [0:(1<<AW)-1];

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;
   rsp_t rsp_q[$];

   int            tests_run    = 0;
   int            tests_failed = 0;
   int            cyc          = 0;
   int            ptr_m        = 0;
   logic          exp_wen      = 1'b0;
   logic          exp_ren      = 1'b0;
   logic [AW-1:0] exp_waddr    = '0;
   logic [AW-1:0] exp_raddr    = '0;
   logic [DW-1:0] exp_wdata    = '0;

   bram18k_port_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .CLK_i         (clk),
      .RST_ni        (rst_n),
      .REQ_VALID_i   (req_valid),
      .REQ_WE_i      (req_we),
      .REQ_ADDR_i    (req_addr),
      .REQ_WDATA_i   (req_wdata),
      .REQ_READY_o   (req_ready),
      .RSP_VALID_o   (rsp_valid),
      .RSP_RDATA_o   (rsp_rdata),
      .RAM_WEN_o     (ram_wen),
      .RAM_REN_o     (ram_ren),
      .RAM_WR_ADDR_o (ram_wr_addr),
      .RAM_RD_ADDR_o (ram_rd_addr),
      .RAM_WDATA_o   (ram_wdata),
      .RAM_RDATA_i   (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_wen) mem[ram_wr_addr] <= ram_wdata;
      if (ram_ren) ram_rdata <= mem[ram_rd_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
      req_valid[k]            = 1'b1;
      req_we[k]               = we;
      req_addr[k*AW +: AW]    = addr;
      req_wdata[k*DW +: DW]   = data;
   endtask

   task automatic clear_all();
      req_valid = '0;
      req_we    = '0;
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v, input int ptr);
      for (int i = 0; i < N; i++) begin
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   // Reference model: checks ready, issue registers and responses, then books the next accept.
   always @(negedge clk) begin
      int            g;
      logic [N-1:0]  exp_rsp;
      logic [AW-1:0] a;
      if (!rst_n) begin
         ptr_m   = 0;
         exp_wen = 1'b0;
         exp_ren = 1'b0;
         rsp_q.delete();
         checkOutput("rst_wen_ren", {30'd0, ram_wen, ram_ren}, 32'd0);
         checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
         g = model_grant(req_valid, ptr_m);
         checkOutput("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));

         checkOutput("ram_wen", 32'(ram_wen), 32'(exp_wen));
         checkOutput("ram_ren", 32'(ram_ren), 32'(exp_ren));
         if (exp_wen) begin
            checkOutput("wr_addr", 32'(ram_wr_addr), 32'(exp_waddr));
            checkOutput("wdata", 32'(ram_wdata), 32'(exp_wdata));
         end
         if (exp_ren) checkOutput("rd_addr", 32'(ram_rd_addr), 32'(exp_raddr));

         exp_rsp = '0;
         if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            exp_rsp = N'(1) << rsp_q[0].id;
            checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q[0].data));
            void'(rsp_q.pop_front());
         end
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));

         exp_wen = 1'b0;
         exp_ren = 1'b0;
         if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            if (req_we[g]) begin
               exp_wen    = 1'b1;
               exp_waddr  = a;
               exp_wdata  = req_wdata[g*DW +: DW];
               ref_mem[a] = exp_wdata;
            end else begin
               exp_ren   = 1'b1;
               exp_raddr = a;
               rsp_q.push_back('{id: g, data: ref_mem[a], due: cyc + 1 + LAT});
            end
            ptr_m = (g + 1) % N;
         end
      end
   end

   initial begin
      logic [AW-1:0] addr_set [5];
      addr_set = '{10'h010, 10'h020, 10'h030, 10'h040, 10'h3FF};
      rst_n     = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      for (int k = 0; k < N; k++) begin
         mem[AW'((k + 1) * 16)]     = DW'((k + 1) * 32'h11);
         ref_mem[AW'((k + 1) * 16)] = DW'((k + 1) * 32'h11);
      end

      applyStimulus(3);
      rst_n = 1'b1;
      applyStimulus(10);

      // All four reading every cycle: grants rotate 0,1,2,3.
      for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'((k + 1) * 16), '0);
      applyStimulus(12);
      clear_all();
      applyStimulus(6);

      // Write then read-back of the top address by a different requester.
      set_req(2, 1'b1, 10'h3FF, 18'h3FFFF);
      applyStimulus(1);
      clear_all();
      set_req(1, 1'b0, 10'h3FF, '0);
      applyStimulus(1);
      clear_all();
      applyStimulus(6);

      // Lone requester 3, then 0 joins.
      set_req(3, 1'b0, 10'h030, '0);
      applyStimulus(5);
      set_req(0, 1'b0, 10'h010, '0);
      applyStimulus(2);
      clear_all();
      applyStimulus(6);

      // Reset lands while a read is in flight.
      set_req(0, 1'b0, 10'h020, '0);
      applyStimulus(1);
      clear_all();
      rst_n = 1'b0;
      applyStimulus(2);
      rst_n = 1'b1;
      applyStimulus(6);
      for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'((k + 1) * 16), '0);
      applyStimulus(1);
      clear_all();
      applyStimulus(6);

      for (int c = 0; c < 80; c++) begin
         for (int k = 0; k < N; k++) begin
            req_valid[k]          = 1'($urandom_range(0, 1));
            req_we[k]             = 1'($urandom_range(0, 1));
            req_addr[k*AW +: AW]  = addr_set[$urandom_range(0, 4)];
            req_wdata[k*DW +: DW] = DW'($urandom_range(0, 18'h3FFFF));
         end
         applyStimulus(1);
      end
      clear_all();
      applyStimulus(8);

      checkOutput("drain", 32'(rsp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bram18k_port_arbiter.md
Name: bram18k_port_arbiter

Overview:
Round-robin arbiter that shares one port of an 18K dual-port BRAM block (one WEN/REN/WR_ADDR/RD_ADDR/WDATA/RDATA port set) between NUM_REQ requesters. Each requester has a valid/ready command interface. The arbiter registers the winning command onto the RAM port and routes synchronous read data back to the issuing requester. Two instances serve both ports of one DPRAM_18K_BLK.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
ADDR_WIDTH, 10, RAM address width (10 for 18x1024, 11 for 9x2048)
DATA_WIDTH, 18, RAM data width (18 or 9)

Ports:
CLK_i  in  1  single clock; also drives the RAM port clock
RST_ni  in  1  asynchronous active-low reset
REQ_VALID_i  in  NUM_REQ  per-requester command valid
REQ_WE_i  in  NUM_REQ  per-requester op select: 1=write, 0=read
REQ_ADDR_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at slice [k*ADDR_WIDTH +: ADDR_WIDTH]
REQ_WDATA_i  in  NUM_REQ*DATA_WIDTH  packed write data, same slicing
REQ_READY_o  out  NUM_REQ  one-hot grant; command accepted when VALID&READY
RSP_VALID_o  out  NUM_REQ  one-hot read-data-valid pulse to the issuing requester
RSP_RDATA_o  out  DATA_WIDTH  shared read data; qualified by RSP_VALID_o
RAM_WEN_o  out  1  to RAM WENx_i
RAM_REN_o  out  1  to RAM RENx_i
RAM_WR_ADDR_o  out  ADDR_WIDTH  to RAM WRx_ADDR_i
RAM_RD_ADDR_o  out  ADDR_WIDTH  to RAM RDx_ADDR_i
RAM_WDATA_o  out  DATA_WIDTH  to RAM WDATAx_i
RAM_RDATA_i  in  DATA_WIDTH  from RAM RDATAx_o

Behaviour:
- Reset (asynchronous, RST_ni low): all registered outputs 0. RAM_WEN_o, RAM_REN_o, addresses, WDATA, RSP_VALID_o and RSP_RDATA_o are 0. Round-robin pointer is 0. The read-tag pipeline is cleared.
- Grant: combinational from REQ_VALID_i and the pointer. It is the first valid requester at or after the pointer, wrapping modulo NUM_REQ. At most one REQ_READY_o is high; none if no valid. READY never depends on WE, ADDR or WDATA.
- The pointer updates only on accept: pointer <= (granted+1) mod NUM_REQ. With no accept, the pointer holds.
- Issue stage: on the accept edge, register the command.
  - Write: RAM_WEN_o=1, RAM_REN_o=0, WR_ADDR/WDATA loaded.
  - Read: RAM_REN_o=1, RAM_WEN_o=0, RD_ADDR loaded.
  - A cycle without accept drives WEN=REN=0; addresses and data hold their last value.
- Throughput: one command per cycle, no bubbles between back-to-back accepts.
- Read return: the RAM has 1-cycle synchronous read. Accept at edge t, RAM samples at edge t+1, and RSP_VALID_o[id] is high for exactly one cycle after edge t+2 with RSP_RDATA_o = RAM_RDATA_i registered. Total read latency is 2 cycles from accept.
- The issuing id is carried in a 2-stage tag pipeline (valid bit + id).
- Writes produce no response.
- Responses return in accept order; no reordering.
- NUM_REQ=1: READY = VALID; the pointer stays 0.
- Simultaneous all-valid from reset: grant order is 0,1,2,...,NUM_REQ-1, then repeats.
- A requester dropping VALID while not granted is legal. There is no starvation: the wait is at most NUM_REQ-1 cycles.
- Reset mid-operation: in-flight reads are discarded; no RSP_VALID_o after reset release until a new read is accepted.

Optional Feature:
BRAM18K_ARB_RDATA_REG_EN
- Defined: an extra register stage on RSP_RDATA_o and RSP_VALID_o (a 3-stage tag pipeline), giving read latency 3 cycles from accept. Intended for timing closure on long BRAM-to-fabric routes.
- Undefined: latency is 2 as above.
- Grant and issue timing are identical either way.

Decomposition:
- Package bram18k_arb_pkg holds:
  - ID_WIDTH as $clog2 of max(NUM_REQ,2);
  - the read-latency localparams (2, or 3 under the macro);
  - a struct typedef for the tag: valid + id.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin grant with pointer register. Inputs are valid and accept; outputs are one-hot grant and encoded id. It is reusable by other shared-resource blocks.

Test Plan:
- Reset release, no valids: REQ_READY_o=0, RAM_WEN_o=RAM_REN_o=0, RSP_VALID_o=0 for 10 cycles.
- NUM_REQ=4, all valid reads every cycle, addrs 0x010/0x020/0x030/0x040 preloaded with 0x00011/0x00022/0x00033/0x00044. Required: grants 0,1,2,3,0,...; RSP_VALID_o[k] arrives 2 cycles after its grant with the matching data.
- Requester 2 writes 0x3FFFF to addr 0x3FF, then requester 1 reads 0x3FF in the next accept. Required: RAM_WEN_o pulse with WR_ADDR=0x3FF; RSP_VALID_o=4'b0010 with RSP_RDATA_o=0x3FFFF.
- Only requester 3 valid for 5 cycles, then 0 and 3 both valid. Required: 3 granted 5 consecutive cycles; pointer wraps to 0, so 0 is granted next, then 3.
- Read accepted, RST_ni asserted 1 cycle later. Required: no RSP_VALID_o after release; pointer is 0.
- With BRAM18K_ARB_RDATA_REG_EN defined, repeat the second scenario. Required: identical grant sequence; responses arrive 3 cycles after accept.
